mod_exp_ctrl: RTL and testbench

Modular-exponentiation controller for the RSA datapath: computes result = M^E mod N by left-to-right square-and-multiply. It sits directly upstream of the shift-subtract `mod` reduction unit. Each square or multiply product is formed locally, then handed to `mod` over a go/done handshake, and the reduced remainder is read back. Parent logic issues one `start` per encryption or decryption and collects `result` on `done`.

---
 rtl/mod_exp_ctrl.sv | 142 ++++++++++++++
 tb/tb_mod_exp_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply controller computing M^E mod N via an external `mod` unit.
// Optional build macro MODEXP_SKIP_LEADING_EN skips squaring while acc is still 1 before the first set exponent bit.
module mod_exp_ctrl #(
  parameter int HALF_W = 4,
  parameter int W      = 2*HALF_W+1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [HALF_W-1:0] M,
  input  logic [HALF_W-1:0] E,
  input  logic [HALF_W-1:0] N,
  output logic              busy,
  output logic              done,
  output logic [HALF_W-1:0] result,
  output logic              err,
  output logic              red_go,
  output logic [W-1:0]      red_x,
  output logic [W-1:0]      red_y,
  input  logic [W-1:0]      red_r,
  input  logic              red_done
);

  localparam int IW = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  typedef enum logic [2:0] {IDLE, SQR, MUL, WAIT, GAP, NEXT, FINISH} state_t;

  state_t            state, state_next;
  logic [HALF_W-1:0] m_q, e_q, n_q, acc;
  logic [IW-1:0]     idx;
  logic              op_mul;
  logic              cnt;
  logic              ebit;
  logic              red_r_unused;
`ifdef MODEXP_SKIP_LEADING_EN
  logic              seen;
`endif

  assign ebit         = e_q[idx];
  assign red_go       = (state == WAIT);
  assign red_r_unused = ^red_r[W-1:HALF_W];

  function automatic logic [W-1:0] product(input logic [HALF_W-1:0] a, input logic [HALF_W-1:0] b);
    logic [2*HALF_W-1:0] p;
    p = {{HALF_W{1'b0}}, a} * {{HALF_W{1'b0}}, b};
    return {{(W-2*HALF_W){1'b0}}, p};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start) state_next = (N < HALF_W'(2)) ? FINISH : SQR;
`ifdef MODEXP_SKIP_LEADING_EN
      SQR:    state_next = seen ? WAIT : (ebit ? MUL : NEXT);
`else
      SQR:    state_next = WAIT;
`endif
      MUL:    state_next = WAIT;
      // The first WAIT cycle never accepts red_done, so WAIT lasts at least 2 cycles.
      WAIT:   if (red_done && cnt) state_next = GAP;
      GAP:    if (cnt) state_next = (!op_mul && ebit) ? MUL : NEXT;
      NEXT:   state_next = (idx == '0) ? FINISH : SQR;
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q    <= '0;
      e_q    <= '0;
      n_q    <= '0;
      acc    <= '0;
      idx    <= IW'(HALF_W-1);
      op_mul <= 1'b0;
      cnt    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      err    <= 1'b0;
      red_x  <= '0;
      red_y  <= '0;
`ifdef MODEXP_SKIP_LEADING_EN
      seen   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          m_q  <= M;
          e_q  <= E;
          n_q  <= N;
          err  <= 1'b0;
          busy <= 1'b1;
          acc  <= (N < HALF_W'(2)) ? '0 : HALF_W'(1);
          idx  <= IW'(HALF_W-1);
`ifdef MODEXP_SKIP_LEADING_EN
          seen <= 1'b0;
`endif
        end
        SQR: if (state_next == WAIT) begin
          red_x  <= {{(W-HALF_W){1'b0}}, n_q};
          red_y  <= product(acc, acc);
          op_mul <= 1'b0;
          cnt    <= 1'b0;
        end
        MUL: begin
          red_x  <= {{(W-HALF_W){1'b0}}, n_q};
          red_y  <= product(acc, m_q);
          op_mul <= 1'b1;
          cnt    <= 1'b0;
`ifdef MODEXP_SKIP_LEADING_EN
          seen   <= 1'b1;
`endif
        end
        WAIT: begin
          if (red_done && cnt) begin
            acc <= red_r[HALF_W-1:0];
            cnt <= 1'b0;
          end else begin
            cnt <= 1'b1;
          end
        end
        GAP:  cnt <= ~cnt;
        NEXT: if (idx != '0) idx <= idx - 1'b1;
        FINISH: begin
          done   <= 1'b1;
          busy   <= 1'b0;
          result <= acc;
          err    <= (n_q == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl: a behavioural `mod` unit with random latency plus a plain-arithmetic exponentiation model.
module tb_mod_exp_ctrl;
  localparam int HW = 4;
  localparam int W  = 2*HW+1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [HW-1:0] M, E, N;
  logic          busy, done, err, red_go, red_done;
  logic [HW-1:0] result;
  logic [W-1:0]  red_x, red_y, red_r;

  int n_cmp = 0;
  int n_bad = 0;

  // Observations made by the `mod` model and the bus monitor.
  int nred = 0;
  int lat_sum = 0;
  int viol = 0;
  int go_cycles = 0;
  int mcnt = 0;
  int cur_lat = 1;
  logic          prev_go = 1'b0;
  logic [W-1:0]  prev_y = '0;
  logic [HW-1:0] cur_n = '0;

  always #5 clk = ~clk;

  mod_exp_ctrl #(.HALF_W(HW), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .M(M), .E(E), .N(N),
    .busy(busy), .done(done), .result(result), .err(err),
    .red_go(red_go), .red_x(red_x), .red_y(red_y), .red_r(red_r), .red_done(red_done)
  );

  // Reduction unit: asserts red_done cur_lat cycles after red_go rises, holds it until red_go drops.
  always @(posedge clk) begin
    if (!red_go) begin
      mcnt     <= 0;
      red_done <= 1'b0;
      red_r    <= '0;
      cur_lat  <= int'($urandom_range(1, 4));
    end else begin
      mcnt <= mcnt + 1;
      if (!red_done && (mcnt + 1 == cur_lat)) begin
        red_done <= 1'b1;
        red_r    <= (red_x != 0) ? (red_y % red_x) : '0;
        nred     <= nred + 1;
        lat_sum  <= lat_sum + cur_lat;
      end
    end
  end

  always @(negedge clk) begin
    prev_go <= red_go;
    prev_y  <= red_y;
    if (rst_n && red_go) begin
      go_cycles <= go_cycles + 1;
      if (red_x !== {{(W-HW){1'b0}}, cur_n} || red_y >= W'(225) || (prev_go && red_y !== prev_y))
        viol <= viol + 1;
    end
  end

  function automatic int model_pow(input int m, input int e, input int n);
    int r;
    if (n < 2) return 0;
    r = 1;
    for (int k = 0; k < e; k++) r = (r * m) % n;
    return r;
  endfunction

  function automatic int model_reds(input int e, input int n);
    int pc, msb;
    pc = 0; msb = -1;
    for (int k = 0; k < HW; k++) if (e[k]) begin pc++; msb = k; end
    if (n < 2) return 0;
`ifdef MODEXP_SKIP_LEADING_EN
    return (msb < 0) ? 0 : msb + pc;
`else
    return HW + pc;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic run(input logic [HW-1:0] m, input logic [HW-1:0] e, input logic [HW-1:0] n, input bit dbl);
    int edges, nred0, lat0, viol0, go0, extra, exp_r;
    bit got;
    nred0 = nred; lat0 = lat_sum; viol0 = viol; go0 = go_cycles;
    exp_r = model_pow(int'(m), int'(e), int'(n));
    cur_n = n;
    @(negedge clk);
    M = m; E = e; N = n; start = 1'b1;
    @(posedge clk); #1;
    edges = 1;
    start = 1'b0;
    M = HW'($urandom); E = HW'($urandom); N = HW'($urandom);
    check("busy_after_start", busy, 1);
    got = 0;
    while (!got && edges < 4000) begin
      if (dbl && edges == 3) start = 1'b1;
      @(posedge clk); #1;
      edges++;
      start = 1'b0;
      if (done) got = 1;
    end
    check("done_seen", got, 1);
    check("result", result, exp_r);
    check("err", err, (n == 0));
    check("busy_at_done", busy, 0);
    check("reductions", nred - nred0, model_reds(int'(e), int'(n)));
    check("bus_violations", viol - viol0, 0);
    if (n < 2) begin
      check("short_latency", edges, 2);
      check("no_go_short", go_cycles - go0, 0);
    end
`ifndef MODEXP_SKIP_LEADING_EN
    else check("latency", edges, 2 + HW + 4*(nred - nred0) + (lat_sum - lat0));
`endif
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("single_done", extra, 0);
    check("result_held", result, exp_r);
  endtask

  initial begin
    int w;
    rst_n = 1'b0; start = 1'b0; M = '0; E = '0; N = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_err", err, 0);
    check("rst_go", red_go, 0);
    check("rst_x", red_x, 0);
    check("rst_y", red_y, 0);
    @(negedge clk); rst_n = 1'b1;

    run(4'd7, 4'd3, 4'd11, 0);
    run(4'd4, 4'd13, 4'd15, 0);
    run(4'd9, 4'd0, 4'd13, 0);
    run(4'd5, 4'd7, 4'd1, 0);
    run(4'd5, 4'd7, 4'd0, 0);
    run(4'd14, 4'd15, 4'd3, 0);
    run(4'd4, 4'd13, 4'd15, 1);

    // Asynchronous reset while a reduction is outstanding.
    cur_n = 4'd11;
    @(negedge clk); M = 4'd7; E = 4'd3; N = 4'd11; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    w = 0;
    while (!red_go && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check("reached_wait", red_go, 1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_go", red_go, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    run(4'd7, 4'd3, 4'd11, 0);

    for (int t = 0; t < 20; t++)
      run(HW'($urandom), HW'($urandom), HW'($urandom_range(0, 15)), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
